// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder sequencer.
//   NIBBLE_W    : width of the shared adder slice
//   state_e     : IDLE / RUN / DONE sequencer states
//   idx_width() : bit width needed to hold a nibble index
package nibble_serial_adder_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // At least one bit, even when only a single nibble is processed.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Request/result bundle between a requester and the nibble-serial adder.
//   start, clear, Cin, A, B : requester -> sequencer
//   ready, done, Sum, Cout  : sequencer -> requester
interface nibble_serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic             clear;
    logic             Cin;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    modport master (
        output start, clear, Cin, A, B,
        input  ready, done, Sum, Cout
    );

    modport slave (
        input  start, clear, Cin, A, B,
        output ready, done, Sum, Cout
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl_adder4.sv
// Single 4-bit ripple slice shared across all nibbles of an operation.
//   i_cin, i_a, i_b : carry-in and operand nibbles
//   o_sum_c, o_cout_c : combinational nibble sum and carry-out
module nibble_serial_adder_ctrl_adder4
    import nibble_serial_adder_ctrl_pkg::*;
(
    input  logic                i_cin,
    input  logic [NIBBLE_W-1:0] i_a,
    input  logic [NIBBLE_W-1:0] i_b,
    output logic [NIBBLE_W-1:0] o_sum_c,
    output logic                o_cout_c
);

    localparam int unsigned EXT_W = NIBBLE_W + 1;

    logic [EXT_W-1:0] w_total;

    assign w_total  = EXT_W'(i_a) + EXT_W'(i_b) + EXT_W'(i_cin);
    assign o_sum_c  = w_total[NIBBLE_W-1:0];
    assign o_cout_c = w_total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Computes WIDTH-bit A+B+Cin one nibble per clock through a single adder4
// slice and a carry register. Operands are captured on the accepting edge,
// the result is published on Sum/Cout together with a one-cycle done pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of the request/result bundle
//                (start/clear/Cin/A/B in, ready/done/Sum/Cout out)
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder_ctrl
    import nibble_serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    nibble_serial_adder_ctrl_if.slave  bus
);

    localparam int unsigned NIBBLES  = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W    = idx_width(NIBBLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    state_e             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_res;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_done;
    logic               r_ready;

    logic [NIBBLE_W-1:0] w_nib_a;
    logic [NIBBLE_W-1:0] w_nib_b;
    logic [NIBBLE_W-1:0] w_sum4;
    logic                w_cout4;
    logic [WIDTH-1:0]    w_res_next;

    // Operand nibble select for the current index.
    always_comb begin
        w_nib_a = '0;
        w_nib_b = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib_a = r_a[i*NIBBLE_W +: NIBBLE_W];
                w_nib_b = r_b[i*NIBBLE_W +: NIBBLE_W];
            end
        end
    end

    nibble_serial_adder_ctrl_adder4 u_adder4 (
        .i_cin    (r_carry),
        .i_a      (w_nib_a),
        .i_b      (w_nib_b),
        .o_sum_c  (w_sum4),
        .o_cout_c (w_cout4)
    );

    // Result nibble insert; kept apart from the select so the adder path
    // does not form a combinational loop through one block.
    always_comb begin
        w_res_next = r_res;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_res_next[i*NIBBLE_W +: NIBBLE_W] = w_sum4;
            end
        end
    end

    // Sequencer: state, working registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            // Abort outranks everything but is meaningless while idle,
            // so a same-cycle start in IDLE still wins.
            if (bus.clear && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_idx   <= '0;
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            r_a     <= bus.A;
                            r_b     <= bus.B;
                            r_carry <= bus.Cin;
                            r_res   <= '0;
                            r_idx   <= '0;
                            r_state <= ST_RUN;
                            r_ready <= 1'b0;
                        end
                    end
                    ST_RUN: begin
                        r_res   <= w_res_next;
                        r_carry <= w_cout4;
                        if (r_idx == IDX_LAST) begin
                            r_idx   <= '0;
                            r_sum   <= w_res_next;
                            r_cout  <= w_cout4;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                    ST_DONE: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.ready = r_ready;
    assign bus.done  = r_done;
    assign bus.Sum   = r_sum;
    assign bus.Cout  = r_cout;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Self-checking bench for nibble_serial_adder_ctrl (WIDTH=16).
module tb_nibble_serial_adder_ctrl;

    localparam int unsigned WIDTH   = 16;
    localparam int          LATENCY = 5;
    localparam int          PERIOD  = 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: full-width sum with carry, straight arithmetic.
    function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    // Launch one op and wait for done; latency counts edges from acceptance.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input bit chk_ready,
                          output int lat, output logic [WIDTH-1:0] s, output logic c);
        lat = -1;
        s   = '0;
        c   = 1'b0;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Cin = cin; bus.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (chk_ready) begin
                n_checks++;
                if (bus.ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ready_busy: cycle %0d got %b expected 0", k, bus.ready);
                end
            end
            if (bus.done === 1'b1) begin
                lat = k; s = bus.Sum; c = bus.Cout;
                break;
            end
        end
    endtask

    task automatic check_result(input string name, input int lat,
                                input logic [WIDTH-1:0] s, input logic c,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic cin);
        logic [WIDTH:0] exp_v;
        exp_v = ref_add(a, b, cin);
        n_checks++;
        if (lat != LATENCY) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d expected %0d", name, lat, LATENCY);
        end
        n_checks++;
        if ({c, s} !== exp_v) begin
            n_fail++;
            $display("FAIL %s_result: got %h expected %h", name, {c, s}, exp_v);
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.clear = 1'b0; bus.Cin = 1'b0; bus.A = '0; bus.B = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.ready, bus.done, bus.Cout, bus.Sum} !== {3'b100, {WIDTH{1'b0}}}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b done=%b cout=%b sum=%h expected 1 0 0 0000",
                     bus.ready, bus.done, bus.Cout, bus.Sum);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_carry_wrap();
        int lat; logic [WIDTH-1:0] s; logic c;
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, s, c);
        check_result("wrap", lat, s, c, 16'hFFFF, 16'h0001, 1'b0);
        n_checks++;
        if (s !== 16'h0000 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_const: got %b_%h expected 1_0000", c, s);
        end
        @(negedge clk);
        n_checks++;
        if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_pulse: got done=%b ready=%b expected 0 1", bus.done, bus.ready);
        end
    endtask

    task automatic test_ready_profile();
        int lat; logic [WIDTH-1:0] s; logic c;
        run_op(16'h1234, 16'h4321, 1'b1, 1'b1, lat, s, c);
        check_result("ready_op", lat, s, c, 16'h1234, 16'h4321, 1'b1);
        n_checks++;
        if (s !== 16'h5556 || c !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_const: got %b_%h expected 0_5556", c, s);
        end
        @(negedge clk);
        n_checks++;
        if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_return: got %b expected 1", bus.ready);
        end
    endtask

    task automatic test_start_ignored();
        int lat = -1;
        int extra_done = 0;
        logic [WIDTH-1:0] s = '0;
        logic c = 1'b0;
        @(negedge clk);
        bus.A = 16'h1111; bus.B = 16'h2222; bus.Cin = 1'b0; bus.start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            bus.start = (k == 2);
            if (k == 2) begin bus.A = 16'h0F0F; bus.B = 16'h00F1; bus.Cin = 1'b1; end
            else        begin bus.A = 16'(($urandom)); bus.B = 16'(($urandom)); end
            if (bus.done === 1'b1) begin
                lat = k; s = bus.Sum; c = bus.Cout;
                break;
            end
            n_checks++;
            if (bus.Sum !== 16'h5556) begin
                n_fail++;
                $display("FAIL hold_prior: cycle %0d got %h expected 5556", k, bus.Sum);
            end
        end
        bus.start = 1'b0;
        check_result("ignored", lat, s, c, 16'h1111, 16'h2222, 1'b0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) extra_done++;
        end
        n_checks++;
        if (extra_done != 0) begin
            n_fail++;
            $display("FAIL ignored_extra_done: got %0d expected 0", extra_done);
        end
    endtask

    task automatic test_clear();
        int lat; int seen = 0; logic [WIDTH-1:0] s; logic c;
        @(negedge clk);
        bus.A = 16'h8000; bus.B = 16'h8000; bus.Cin = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;   // RUN cycle 1
        @(negedge clk);                     // RUN cycle 2
        @(negedge clk); bus.clear = 1'b1;   // RUN cycle 3
        @(negedge clk); bus.clear = 1'b0;
        n_checks++;
        if ({bus.ready, bus.done, bus.Cout, bus.Sum} !== {3'b100, 16'h3333}) begin
            n_fail++;
            $display("FAIL clear_abort: got rdy=%b done=%b cout=%b sum=%h expected 1 0 0 3333",
                     bus.ready, bus.done, bus.Cout, bus.Sum);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL clear_no_done: got %0d expected 0", seen);
        end
        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, lat, s, c);
        check_result("after_clear", lat, s, c, 16'h8000, 16'h8000, 1'b0);
    endtask

    task automatic test_async_reset();
        int seen = 0;
        @(negedge clk);
        bus.A = 16'h1234; bus.B = 16'h4321; bus.Cin = 1'b0; bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.ready, bus.done, bus.Cout, bus.Sum} !== {3'b100, {WIDTH{1'b0}}}) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b done=%b cout=%b sum=%h expected 1 0 0 0000",
                     bus.ready, bus.done, bus.Cout, bus.Sum);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0 || bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_after: got dones=%0d ready=%b expected 0 1", seen, bus.ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH:0] exp_q[$];
        logic [WIDTH:0] exp_v;
        int accepted = 0, dones = 0, cycle = 0, last_done = -1;
        bus.clear = 1'b0;
        while ((accepted < 1000 || exp_q.size() > 0) && cycle < 7000) begin
            @(negedge clk);
            cycle++;
            if (bus.done === 1'b1) begin
                dones++;
                if (last_done >= 0) begin
                    n_checks++;
                    if (cycle - last_done != PERIOD) begin
                        n_fail++;
                        $display("FAIL b2b_spacing: got %0d expected %0d", cycle - last_done, PERIOD);
                    end
                end
                last_done = cycle;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_spurious_done: got %b_%h expected none", bus.Cout, bus.Sum);
                end else begin
                    exp_v = exp_q.pop_front();
                    if ({bus.Cout, bus.Sum} !== exp_v) begin
                        n_fail++;
                        $display("FAIL b2b_result: op %0d got %h expected %h", dones, {bus.Cout, bus.Sum}, exp_v);
                    end
                end
            end
            bus.A   = 16'($urandom);
            bus.B   = 16'($urandom);
            bus.Cin = 1'($urandom);
            if (bus.ready === 1'b1) begin
                if (accepted < 1000) begin
                    bus.start = 1'b1;
                    exp_q.push_back(ref_add(bus.A, bus.B, bus.Cin));
                    accepted++;
                end else begin
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        n_checks++;
        if (dones != 1000 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d dones (%0d pending) expected 1000", dones, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_ready_profile();
        test_start_ignored();
        test_clear();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
